traffic_conflict_monitor: RTL
=============================

# traffic_conflict_monitor

Safety stage directly downstream of the traffic light controller. It takes the controller's north-south and east-west lamp codes and passes them to the lamp drivers with a one-cycle register delay. It continuously checks them for conflicting greens, illegal lamp codes and unsafe phase sequences. On a fault it latches a fault code, forces both directions to flashing red until cleared, then runs a solid all-red recovery interval before it resumes pass-through.

## Interface
- PERSIST, 2: consecutive sampled cycles a conflict or illegal code must hold before tripping (≥1).
- MIN_YELLOW, 3: minimum consecutive yellow cycles before a yellow→red transition is legal.
- FLASH_HALF, 4: cycles per half-period of the fault flash (≥1).
- ALLRED, 8: cycles of solid all-red in recovery (≥1).
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- nsl_in  in  3  controller north-south lamp code {red,yellow,green}.
- ewl_in  in  3  controller east-west lamp code {red,yellow,green}.
- clear  in  1  operator fault acknowledge; level-sampled, acted on only in FLASH.
- nsl  out  3  north-south lamp drive {red,yellow,green}.
- ewl  out  3  east-west lamp drive {red,yellow,green}.
- fault  out  1  high from trip until recovery completes.
- fault_code  out  2  00 none, 01 conflict, 10 illegal code, 11 sequence error; held while fault=1.

## Operation
- States: MON (pass-through and checking), FLASH (tripped), RECOVER (solid all-red). Reset → MON.
- **MON:** nsl<=nsl_in, ewl<=ewl_in every edge. The checks below run on every sampled pair.
- **Conflict:** both directions have yellow or green set. Its persistence counter increments while the condition holds and clears to 0 when it does not.
- **Illegal:** either code is not one-hot (000, 011, 101, 110, 111). It has its own persistence counter with the same rule.
- **Sequence:** per direction, the previous sampled code is registered; reset value is 100. A yellow-run counter counts consecutive yellow samples and saturates at MIN_YELLOW.
  - Error if the previous code is green and the current code is red.
  - Error if the previous code is yellow, the current code is red, and the yellow run is less than MIN_YELLOW.
  - A sequence error trips immediately, with no persistence.
- **Trip:** happens on the edge where a persistence counter reaches PERSIST, or a sequence error is sampled. On that edge: state<=FLASH, fault<=1, fault_code loaded, nsl=ewl<=100, flash phase counter<=0.
- **Simultaneous trips:** priority is conflict (01) > illegal (10) > sequence (11).
- **FLASH:**
  - Red bit toggles every FLASH_HALF cycles, starting lit; yellow and green are always 0.
  - Inputs are ignored and no new fault_code loads.
  - clear=1 sampled → RECOVER, and nsl=ewl<=100 on that edge.
- **RECOVER:**
  - Solid 100 on both directions for exactly ALLRED cycles.
  - clear and faults are ignored.
  - On the final edge: state<=MON, fault<=0, fault_code<=00, persistence counters, yellow-run counters and previous-code registers cleared to reset values, outputs<=current inputs.
- clear in MON has no effect.

## Timing
- Reset values: nsl=100, ewl=100, fault=0, fault_code=00, state MON, all counters 0, previous codes 100.
- Reset asserted in any state returns to these values immediately.
- Pass-through latency is 1 cycle.
- **Trip latency:** a conflict or illegal code first sampled at edge N trips at edge N+PERSIST-1. A sequence error trips on the edge that samples it. Outputs, fault and fault_code change together on that edge.
- **Flash:** red lit for the FLASH_HALF edges after entry, dark for the next FLASH_HALF, and so on.
- **Recovery:** fault drops ALLRED edges after the clear edge.
- A normal controller cycle (green 6 cycles, yellow 3, other direction red) must never trip with default parameters.

## Configuration
- TLMON_SEQ_CHECK_EN defined: the sequence checks, previous-code registers and yellow-run counters are compiled in.
- Undefined: that logic is absent, only conflict and illegal checks exist, and fault_code 11 is never produced. All other behaviour is unchanged.

## Test plan
- **Normal sequence:** drive the controller sequence (001/100 ×6, 010/100 ×3, 100/001 ×6, 100/010 ×3) for 40 cycles → fault=0 throughout; nsl/ewl equal the inputs delayed 1 cycle.
- **Conflict:** nsl_in=ewl_in=001 for 1 cycle, then legal → no trip. The same pair for 2 cycles → fault=1 and fault_code=01 on the 2nd edge. nsl=ewl=100 for 4 cycles, then 000 for 4, repeating.
- **Illegal / priority:** nsl_in=011 with ewl_in=100 for 2 cycles → fault_code=10. Conflict and illegal maturing on the same edge → 01.
- **Sequence** (macro defined): nsl_in 010 for 2 cycles then 100 → trip on the red sample with code 11. 001 directly to 100 → code 11. With the macro undefined → no trip.
- **Clear and recovery:** in FLASH, pulse clear for 1 cycle → solid 100/100 for 8 cycles, then fault=0, fault_code=00 and pass-through resumes. clear pulses during RECOVER are ignored.
- **Reset during FLASH:** assert reset mid-flash → outputs go to 100/100 and fault=0 immediately. After release, legal inputs pass through with no trip.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Optional phase-sequence checking is compiled in with TLMON_SEQ_CHECK_EN.
module traffic_conflict_monitor #(
    parameter int PERSIST    = 2,
    parameter int MIN_YELLOW = 3,
    parameter int FLASH_HALF = 4,
    parameter int ALLRED     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] nsl_in,
    input  logic [2:0] ewl_in,
    input  logic       clear,
    output logic [2:0] nsl,
    output logic [2:0] ewl,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int PW = $clog2(PERSIST + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int RW = $clog2(ALLRED + 1);
    localparam logic [2:0] RED = 3'b100;

    typedef enum logic [1:0] {
        MON     = 2'd0,
        FLASH   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    nsl_q, nsl_d;
    logic [2:0]    ewl_q, ewl_d;
    logic          fault_q, fault_d;
    logic [1:0]    code_q, code_d;
    logic [PW-1:0] conf_q, conf_d;
    logic [PW-1:0] ill_q, ill_d;
    logic [FW-1:0] flash_q, flash_d;
    logic [RW-1:0] rec_q, rec_d;

    logic conflict, illegal;
    logic trip_conf, trip_ill, seq_err, trip;
    logic rec_done;

    function automatic logic onehot3(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    assign conflict  = (|nsl_in[1:0]) && (|ewl_in[1:0]);
    assign illegal   = !onehot3(nsl_in) || !onehot3(ewl_in);
    assign trip_conf = conflict && (conf_q == PW'(PERSIST - 1));
    assign trip_ill  = illegal && (ill_q == PW'(PERSIST - 1));
    assign trip      = trip_conf || trip_ill || seq_err;
    assign rec_done  = (rec_q == RW'(ALLRED - 1));

`ifdef TLMON_SEQ_CHECK_EN
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic [2:0]    nsp_q, nsp_d;
    logic [2:0]    ewp_q, ewp_d;
    logic [YW-1:0] nsy_q, nsy_d;
    logic [YW-1:0] ewy_q, ewy_d;
    logic          chk_clr;

    function automatic logic bad_step(
        input logic [2:0]    p,
        input logic [2:0]    c,
        input logic [YW-1:0] y
    );
        return (c == RED) &&
               ((p == GRN) ||
                ((p == YEL) && (y < YW'(MIN_YELLOW))));
    endfunction

    function automatic logic [YW-1:0] yrun(
        input logic [2:0]    c,
        input logic [YW-1:0] y
    );
        if (c != YEL) return '0;
        if (y == YW'(MIN_YELLOW)) return y;
        return y + YW'(1);
    endfunction

    assign seq_err = (state_q == MON) &&
                     (bad_step(nsp_q, nsl_in, nsy_q) ||
                      bad_step(ewp_q, ewl_in, ewy_q));
    assign chk_clr = ((state_q == MON) && trip) ||
                     ((state_q == RECOVER) && rec_done);

    // track last sampled code and yellow run per direction
    always_comb begin
        nsp_d = nsp_q;
        ewp_d = ewp_q;
        nsy_d = nsy_q;
        ewy_d = ewy_q;
        if (chk_clr) begin
            nsp_d = RED;
            ewp_d = RED;
            nsy_d = '0;
            ewy_d = '0;
        end else if (state_q == MON) begin
            nsp_d = nsl_in;
            ewp_d = ewl_in;
            nsy_d = yrun(nsl_in, nsy_q);
            ewy_d = yrun(ewl_in, ewy_q);
        end
    end

    // sequence-check history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nsp_q <= RED;
            ewp_q <= RED;
            nsy_q <= '0;
            ewy_q <= '0;
        end else begin
            nsp_q <= nsp_d;
            ewp_q <= ewp_d;
            nsy_q <= nsy_d;
            ewy_q <= ewy_d;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= MON;
        else       state_q <= state_d;
    end

    // next-state: trip, operator clear, end of all-red
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MON:     if (trip)     state_d = FLASH;
            FLASH:   if (clear)    state_d = RECOVER;
            RECOVER: if (rec_done) state_d = MON;
            default:               state_d = MON;
        endcase
    end

    // lamp drive, fault flags and counters for each state
    always_comb begin
        nsl_d   = nsl_q;
        ewl_d   = ewl_q;
        fault_d = fault_q;
        code_d  = code_q;
        conf_d  = conf_q;
        ill_d   = ill_q;
        flash_d = flash_q;
        rec_d   = rec_q;
        unique case (state_q)
            MON: begin
                nsl_d  = nsl_in;
                ewl_d  = ewl_in;
                conf_d = conflict ? conf_q + PW'(1) : '0;
                ill_d  = illegal ? ill_q + PW'(1) : '0;
                if (trip) begin
                    nsl_d   = RED;
                    ewl_d   = RED;
                    fault_d = 1'b1;
                    flash_d = '0;
                    conf_d  = '0;
                    ill_d   = '0;
                    if (trip_conf)     code_d = 2'b01;
                    else if (trip_ill) code_d = 2'b10;
                    else               code_d = 2'b11;
                end
            end
            FLASH: begin
                if (clear) begin
                    nsl_d = RED;
                    ewl_d = RED;
                    rec_d = '0;
                end else if (flash_q == FW'(FLASH_HALF - 1)) begin
                    flash_d = '0;
                    nsl_d   = nsl_q ^ RED;
                    ewl_d   = ewl_q ^ RED;
                end else begin
                    flash_d = flash_q + FW'(1);
                end
            end
            RECOVER: begin
                if (rec_done) begin
                    nsl_d   = nsl_in;
                    ewl_d   = ewl_in;
                    fault_d = 1'b0;
                    code_d  = 2'b00;
                    conf_d  = '0;
                    ill_d   = '0;
                    rec_d   = '0;
                end else begin
                    rec_d = rec_q + RW'(1);
                end
            end
            default: ;
        endcase
    end

    // output and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nsl_q   <= RED;
            ewl_q   <= RED;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
            conf_q  <= '0;
            ill_q   <= '0;
            flash_q <= '0;
            rec_q   <= '0;
        end else begin
            nsl_q   <= nsl_d;
            ewl_q   <= ewl_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            conf_q  <= conf_d;
            ill_q   <= ill_d;
            flash_q <= flash_d;
            rec_q   <= rec_d;
        end
    end

    assign nsl        = nsl_q;
    assign ewl        = ewl_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
endmodule
